// File: rtl/pong_pkg.sv
// Pong playfield shared definitions: geometry, motion and scoring constants,
// game state encoding, ball position payload and small arithmetic helpers.
package pong_pkg;

  localparam int unsigned COORD_W     = 10;  // on-screen coordinate width
  localparam int unsigned EXT_W       = 11;  // widened coordinate for no-wrap compares
  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned CNT_W       = 6;   // serve countdown width

  localparam int unsigned Y_CEIL      = 48;
  localparam int unsigned Y_FLOOR     = 432;
  localparam int unsigned X_LWALL     = 64;
  localparam int unsigned X_RWALL     = 576;
  localparam int unsigned BALL_W      = 10;
  localparam int unsigned BALL_H      = 10;
  localparam int unsigned PAD_W       = 12;
  localparam int unsigned PAD_H       = 100;
  localparam int unsigned X_PADA      = 100;
  localparam int unsigned X_PADB      = 530;
  localparam int unsigned SPEED       = 2;
  localparam int unsigned SERVE_TICKS = 60;
  localparam int unsigned WIN_SCORE   = 9;

  localparam int unsigned X_CENTRE    = 315;
  localparam int unsigned Y_CENTRE    = 235;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ball_pos_t;

  localparam ball_pos_t CENTRE_POS = '{x: COORD_W'(X_CENTRE), y: COORD_W'(Y_CENTRE)};

  // Zero-extend a screen coordinate so +/- SPEED and size offsets never wrap.
  function automatic logic [EXT_W-1:0] ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

  // Score increment that sticks at the winning score.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(WIN_SCORE)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/paddle_hit_detect.sv
// Combinational paddle collision test for one paddle.
// Ports:
//   ball_x, ball_y : current ball top-left corner
//   dx_pos         : 1 = ball moving right, 0 = moving left
//   pad_y          : paddle top y (sampled by the caller at the tick)
//   hit_c          : ball is approaching this paddle's face, crosses it within
//                    one step, and overlaps the paddle vertically
// LEFT_SIDE selects which face is tested: the right face of the left paddle,
// or the left face of the right paddle. PAD_X is the paddle's left edge.
module paddle_hit_detect
  import pong_pkg::*;
#(
  parameter bit          LEFT_SIDE = 1'b1,
  parameter int unsigned PAD_X     = X_PADA
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic               dx_pos,
  input  logic [COORD_W-1:0] pad_y,
  output logic               hit_c
);

  localparam logic [EXT_W-1:0] SPEED_E  = EXT_W'(SPEED);
  localparam logic [EXT_W-1:0] BALL_W_E = EXT_W'(BALL_W);
  localparam logic [EXT_W-1:0] BALL_H_E = EXT_W'(BALL_H);
  localparam logic [EXT_W-1:0] PAD_H_E  = EXT_W'(PAD_H);

  logic [EXT_W-1:0] lead;
  logic [EXT_W-1:0] face;
  logic             approach;
  logic             overlap;

  // Leading ball edge vs. paddle face, in the direction of travel.
  always_comb begin
    lead     = '0;
    face     = '0;
    approach = 1'b0;
    if (LEFT_SIDE) begin
      face     = EXT_W'(PAD_X + PAD_W);
      lead     = ext(ball_x);
      approach = !dx_pos && (lead >= face) && (lead <= face + SPEED_E);
    end else begin
      face     = EXT_W'(PAD_X);
      lead     = ext(ball_x) + BALL_W_E;
      approach = dx_pos && (lead <= face) && (lead + SPEED_E >= face);
    end
  end

  // Strict inequalities: touching edges do not count as overlap.
  always_comb begin
    overlap = (ext(ball_y) + BALL_H_E > ext(pad_y)) &&
              (ext(ball_y) < ext(pad_y) + PAD_H_E);
    hit_c   = approach && overlap;
  end

endmodule

// File: rtl/pong_game_controller.sv
// Pong game sequencer: ball position/direction, wall and paddle collisions,
// scoring and the IDLE/SERVE/PLAY/OVER flow. Game state advances only on
// game_tick pulses; start is the one input acted on without a tick.
// Ports:
//   vga_clk, rst_n          : pixel clock, async active-low reset
//   game_tick               : one-cycle frame pulse, advances the game one step
//   start                   : level, starts a game from IDLE or OVER
//   y_paddleA, y_paddleB    : paddle top y positions
//   x_ball, y_ball          : ball top-left corner (registered)
//   score_a, score_b        : player scores (registered)
//   game_over               : high while in OVER (registered)
//   state                   : IDLE=0 SERVE=1 PLAY=2 OVER=3 (registered)
module pong_game_controller
  import pong_pkg::*;
(
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               game_tick,
  input  logic               start,
  input  logic [COORD_W-1:0] y_paddleA,
  input  logic [COORD_W-1:0] y_paddleB,
  output logic [COORD_W-1:0] x_ball,
  output logic [COORD_W-1:0] y_ball,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam logic [EXT_W-1:0]   SPEED_E    = EXT_W'(SPEED);
  localparam logic [EXT_W-1:0]   BALL_W_E   = EXT_W'(BALL_W);
  localparam logic [EXT_W-1:0]   BALL_H_E   = EXT_W'(BALL_H);
  localparam logic [EXT_W-1:0]   Y_CEIL_E   = EXT_W'(Y_CEIL);
  localparam logic [EXT_W-1:0]   Y_FLOOR_E  = EXT_W'(Y_FLOOR);
  localparam logic [EXT_W-1:0]   X_LWALL_E  = EXT_W'(X_LWALL);
  localparam logic [EXT_W-1:0]   X_RWALL_E  = EXT_W'(X_RWALL);
  localparam logic [COORD_W-1:0] PAD_A_FACE = COORD_W'(X_PADA + PAD_W);
  localparam logic [COORD_W-1:0] PAD_B_STOP = COORD_W'(X_PADB - BALL_W);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  ball_pos_t          pos_q, pos_d;
  logic               dx_pos_q, dx_pos_d;
  logic               dy_pos_q, dy_pos_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               game_over_q, game_over_d;

  logic               hit_a_c;
  logic               hit_b_c;
  logic [EXT_W-1:0]   x_e;
  logic [EXT_W-1:0]   y_e;
  logic [EXT_W-1:0]   y_mv;
  logic               dy_mv;
  logic               miss_left;
  logic               miss_right;

  paddle_hit_detect #(
    .LEFT_SIDE (1'b1),
    .PAD_X     (X_PADA)
  ) u_hit_a (
    .ball_x (pos_q.x),
    .ball_y (pos_q.y),
    .dx_pos (dx_pos_q),
    .pad_y  (y_paddleA),
    .hit_c  (hit_a_c)
  );

  paddle_hit_detect #(
    .LEFT_SIDE (1'b0),
    .PAD_X     (X_PADB)
  ) u_hit_b (
    .ball_x (pos_q.x),
    .ball_y (pos_q.y),
    .dx_pos (dx_pos_q),
    .pad_y  (y_paddleB),
    .hit_c  (hit_b_c)
  );

  // Vertical step with floor/ceiling clamp and bounce.
  always_comb begin
    y_e   = ext(pos_q.y);
    y_mv  = y_e;
    dy_mv = dy_pos_q;
    if (dy_pos_q) begin
      if (y_e + BALL_H_E + SPEED_E >= Y_FLOOR_E) begin
        y_mv  = Y_FLOOR_E - BALL_H_E;
        dy_mv = 1'b0;
      end else begin
        y_mv  = y_e + SPEED_E;
      end
    end else begin
      if (y_e <= Y_CEIL_E + SPEED_E) begin
        y_mv  = Y_CEIL_E;
        dy_mv = 1'b1;
      end else begin
        y_mv  = y_e - SPEED_E;
      end
    end
  end

  // Goal-line crossing within this step; only used when no paddle hit.
  always_comb begin
    x_e        = ext(pos_q.x);
    miss_left  = !dx_pos_q && (x_e <= X_LWALL_E + SPEED_E);
    miss_right = dx_pos_q && (x_e + BALL_W_E + SPEED_E >= X_RWALL_E);
  end

  // Game FSM and playfield next-state.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dx_pos_d    = dx_pos_q;
    dy_pos_d    = dy_pos_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    serve_cnt_d = serve_cnt_q;

    case (state_q)
      IDLE: begin
        pos_d = CENTRE_POS;
        if (start) begin
          state_d     = SERVE;
          serve_cnt_d = '0;
        end
      end

      SERVE: begin
        if (game_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (game_tick) begin
          if (hit_a_c) begin
            pos_d.x  = PAD_A_FACE;
            pos_d.y  = COORD_W'(y_mv);
            dx_pos_d = 1'b1;
            dy_pos_d = dy_mv;
          end else if (hit_b_c) begin
            pos_d.x  = PAD_B_STOP;
            pos_d.y  = COORD_W'(y_mv);
            dx_pos_d = 1'b0;
            dy_pos_d = dy_mv;
          end else if (miss_left) begin
            // A conceded: recentre and serve toward A; dy is left as it was.
            score_b_d   = sat_inc(score_b_q);
            pos_d       = CENTRE_POS;
            dx_pos_d    = 1'b0;
            serve_cnt_d = '0;
            state_d     = (score_b_d == WIN_S) ? OVER : SERVE;
          end else if (miss_right) begin
            score_a_d   = sat_inc(score_a_q);
            pos_d       = CENTRE_POS;
            dx_pos_d    = 1'b1;
            serve_cnt_d = '0;
            state_d     = (score_a_d == WIN_S) ? OVER : SERVE;
          end else begin
            pos_d.x  = dx_pos_q ? COORD_W'(x_e + SPEED_E) : COORD_W'(x_e - SPEED_E);
            pos_d.y  = COORD_W'(y_mv);
            dy_pos_d = dy_mv;
          end
        end
      end

      OVER: begin
        pos_d = CENTRE_POS;
        if (start) begin
          score_a_d   = '0;
          score_b_d   = '0;
          serve_cnt_d = '0;
          state_d     = SERVE;
        end
      end

      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  // State and playfield registers.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= CENTRE_POS;
      dx_pos_q    <= 1'b1;
      dy_pos_q    <= 1'b1;
      score_a_q   <= '0;
      score_b_q   <= '0;
      serve_cnt_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dx_pos_q    <= dx_pos_d;
      dy_pos_q    <= dy_pos_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      serve_cnt_q <= serve_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign x_ball    = pos_q.x;
  assign y_ball    = pos_q.y;
  assign score_a   = score_a_q;
  assign score_b   = score_b_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Scoreboard bench for pong_game_controller: the driver pushes expected
// outputs (hand values at key points, otherwise a behavioural model) and a
// monitor pops and compares after each driven clock edge or async reset.
module tb_pong_game_controller;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic       game_tick;
  logic       start;
  logic [9:0] y_paddleA;
  logic [9:0] y_paddleB;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       game_over;
  logic [1:0] state;

  always #5 vga_clk = ~vga_clk;

  pong_game_controller dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .game_tick (game_tick),
    .start     (start),
    .y_paddleA (y_paddleA),
    .y_paddleB (y_paddleB),
    .x_ball    (x_ball),
    .y_ball    (y_ball),
    .score_a   (score_a),
    .score_b   (score_b),
    .game_over (game_over),
    .state     (state)
  );

  typedef struct {
    int x;
    int y;
    int sa;
    int sb;
    int st;
    int go;
    int tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;
  logic obs   = 1'b0;
  event async_ev;

  // Behavioural model state; dx/dy are +1/-1.
  int m_x, m_y, m_dx, m_dy, m_sa, m_sb, m_st, m_cnt;

  task automatic model_reset();
    m_x = 315; m_y = 235; m_dx = 1; m_dy = 1;
    m_sa = 0; m_sb = 0; m_st = 0; m_cnt = 0;
  endtask

  function automatic bit overlap(input int y, input int py);
    return (y + 10 > py) && (y < py + 100);
  endfunction

  task automatic model_clk(input bit tk, input bit st, input int pa, input int pb);
    int ny, ndy;
    case (m_st)
      0: if (st) begin m_st = 1; m_cnt = 0; end
      1: if (tk) begin
           if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
           else m_cnt++;
         end
      2: if (tk) begin
           ny = m_y + 2 * m_dy;
           ndy = m_dy;
           if (m_dy > 0 && m_y + 12 >= 432) begin ny = 422; ndy = -1; end
           if (m_dy < 0 && m_y <= 50) begin ny = 48; ndy = 1; end
           if (m_dx < 0 && m_x >= 112 && m_x - 2 <= 112 && overlap(m_y, pa)) begin
             m_x = 112; m_dx = 1; m_y = ny; m_dy = ndy;
           end else if (m_dx > 0 && m_x + 10 <= 530 && m_x + 12 >= 530 && overlap(m_y, pb)) begin
             m_x = 520; m_dx = -1; m_y = ny; m_dy = ndy;
           end else if (m_dx < 0 && m_x - 2 <= 64) begin
             if (m_sb < 9) m_sb++;
             m_x = 315; m_y = 235; m_dx = -1; m_cnt = 0;
             m_st = (m_sb == 9) ? 3 : 1;
           end else if (m_dx > 0 && m_x + 12 >= 576) begin
             if (m_sa < 9) m_sa++;
             m_x = 315; m_y = 235; m_dx = 1; m_cnt = 0;
             m_st = (m_sa == 9) ? 3 : 1;
           end else begin
             m_x = m_x + 2 * m_dx; m_y = ny; m_dy = ndy;
           end
         end
      default: if (st) begin m_sa = 0; m_sb = 0; m_st = 1; m_cnt = 0; end
    endcase
  endtask

  function automatic exp_t mk(input int x, input int y, input int sa, input int sb, input int st);
    exp_t e;
    e.x = x; e.y = y; e.sa = sa; e.sb = sb; e.st = st;
    e.go = (st == 3) ? 1 : 0;
    e.tag = 0;
    return e;
  endfunction

  // One driven cycle: inputs applied at the falling edge, expectation queued.
  task automatic cyc(input bit tk, input bit st, input bit hand, input exp_t hv);
    exp_t e;
    @(negedge vga_clk);
    game_tick = tk;
    start     = st;
    obs       = 1'b1;
    model_clk(tk, st, int'(y_paddleA), int'(y_paddleB));
    if (hand) e = hv;
    else e = mk(m_x, m_y, m_sa, m_sb, m_st);
    e.tag = phase;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit tk, input bit st);
    cyc(tk, st, 1'b0, mk(0, 0, 0, 0, 0));
  endtask

  task automatic step_h(input bit tk, input bit st, input int x, input int y,
                        input int sa, input int sb, input int s);
    cyc(tk, st, 1'b1, mk(x, y, sa, sb, s));
  endtask

  // Paddle mode 0 tracks the ball (always overlaps); 1 stays clear of it.
  task automatic set_pads(input bit a_avoid, input bit b_avoid);
    logic [9:0] trk, avd;
    trk = 10'(m_y - 45);
    avd = (m_y > 250) ? 10'd0 : 10'd300;
    y_paddleA = a_avoid ? avd : trk;
    y_paddleB = b_avoid ? avd : trk;
  endtask

  // Tick until the model leaves its current state; start is pulsed in idle
  // cycles only while SERVE/PLAY, where it must be ignored.
  task automatic run_until_change(input int bound, input bit a_avoid, input bit b_avoid);
    int s0, n;
    s0 = m_st;
    n = 0;
    while (m_st == s0 && n < bound) begin
      set_pads(a_avoid, b_avoid);
      step(1'b1, 1'b0);
      step(1'b0, (m_st == 1 || m_st == 2) && (n % 5 == 0));
      n++;
    end
    if (m_st == s0) begin
      total++; bad++;
      $display("FAIL state_change_timeout phase%0d: still state %0d after %0d ticks", phase, s0, bound);
    end
  endtask

  task automatic check_one();
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: DUT output observed with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    if (x_ball !== 10'(e.x) || y_ball !== 10'(e.y) || score_a !== 4'(e.sa) ||
        score_b !== 4'(e.sb) || state !== 2'(e.st) || game_over !== 1'(e.go)) begin
      bad++;
      $display("FAIL outputs phase%0d t=%0t: got x=%0d y=%0d sa=%0d sb=%0d st=%0d go=%0d, want x=%0d y=%0d sa=%0d sb=%0d st=%0d go=%0d",
               e.tag, $time, x_ball, y_ball, score_a, score_b, state, game_over,
               e.x, e.y, e.sa, e.sb, e.st, e.go);
    end
  endtask

  always @(posedge vga_clk) begin
    if (obs) begin
      #1;
      check_one();
    end
  end

  always @(async_ev) begin
    #1;
    check_one();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; game_tick = 1'b0; start = 1'b0;
    y_paddleA = 10'd0; y_paddleB = 10'd0;
    model_reset();
    #12 rst_n = 1'b1;

    // Reset values, tick ignored in IDLE, start with a coincident tick.
    phase = 1;
    step_h(1'b0, 1'b0, 315, 235, 0, 0, 0);
    step_h(1'b1, 1'b0, 315, 235, 0, 0, 0);
    step_h(1'b1, 1'b1, 315, 235, 0, 0, 1);

    // Serve countdown: 60 ticks to PLAY, no motion.
    phase = 2;
    for (int i = 1; i <= 60; i++) begin
      set_pads(1'b0, 1'b0);
      if (i == 59)      step_h(1'b1, 1'b0, 315, 235, 0, 0, 1);
      else if (i == 60) step_h(1'b1, 1'b0, 315, 235, 0, 0, 2);
      else              step(1'b1, 1'b0);
      step(1'b0, (i % 7) == 0);
    end

    // Play: first move, floor clamp/bounce, paddle B return.
    phase = 3;
    for (int k = 1; k <= 104; k++) begin
      set_pads(1'b0, 1'b0);
      case (k)
        1:       step_h(1'b1, 1'b0, 317, 237, 0, 0, 2);
        94:      step_h(1'b1, 1'b0, 503, 422, 0, 0, 2);
        95:      step_h(1'b1, 1'b0, 505, 420, 0, 0, 2);
        103:     step_h(1'b1, 1'b0, 520, 404, 0, 0, 2);
        104:     step_h(1'b1, 1'b0, 518, 402, 0, 0, 2);
        default: step(1'b1, 1'b0);
      endcase
      step(1'b0, (k % 9) == 0);
    end

    // Paddle A returns, paddle B misses: A scores, ball recentred in SERVE.
    phase = 4;
    run_until_change(2000, 1'b0, 1'b1);
    step_h(1'b0, 1'b0, 315, 235, 1, 0, 1);

    // A scores until the game ends; OVER ignores ticks, start restarts.
    phase = 5;
    for (int r = 0; r < 20 && m_st != 3; r++) run_until_change(2000, 1'b0, 1'b1);
    step_h(1'b0, 1'b0, 315, 235, 9, 0, 3);
    for (int j = 0; j < 3; j++) step_h(1'b1, 1'b0, 315, 235, 9, 0, 3);
    step_h(1'b0, 1'b1, 315, 235, 0, 0, 1);

    // Paddle B returns, paddle A misses: B scores.
    phase = 6;
    run_until_change(200, 1'b1, 1'b0);
    run_until_change(2000, 1'b1, 1'b0);
    step_h(1'b0, 1'b0, 315, 235, 0, 1, 1);
    run_until_change(200, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      set_pads(1'b1, 1'b0);
      step(1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of PLAY.
    phase = 7;
    @(negedge vga_clk);
    obs = 1'b0; game_tick = 1'b0; start = 1'b0;
    #2;
    model_reset();
    begin
      exp_t e;
      e = mk(315, 235, 0, 0, 0);
      e.tag = phase;
      sb_q.push_back(e);
    end
    rst_n = 1'b0;
    -> async_ev;
    @(negedge vga_clk);
    #2 rst_n = 1'b1;
    step_h(1'b0, 1'b0, 315, 235, 0, 0, 0);
    step_h(1'b1, 1'b0, 315, 235, 0, 0, 0);

    @(negedge vga_clk);
    obs = 1'b0; game_tick = 1'b0;
    repeat (2) @(negedge vga_clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d expectations never checked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
